// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the execute-stage multiply/divide scheduler.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      WB,
      HOLD
   } md_state_t;

   localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_sched_div.sv
// Unsigned restoring divider producing one quotient bit per cycle.
module div_radix2
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dsr_q;
   logic [5:0]  cnt_q;
   logic        run_q;
   logic [32:0] shifted;
   logic [32:0] diff;
   logic        trial_ok;

   // A non-negative trial difference means the divisor fits and the quotient bit is 1.
   always_comb begin
      shifted  = {rem_q, quo_q[31]};
      diff     = shifted - {1'b0, dsr_q};
      trial_ok = ~diff[32];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (abort) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         rem_q <= '0;
         quo_q <= dividend;
         dsr_q <= divisor;
         cnt_q <= 6'(DIV_ITERS);
         run_q <= 1'b1;
      end else if (run_q) begin
         rem_q <= trial_ok ? diff[31:0] : shifted[31:0];
         quo_q <= {quo_q[30:0], trial_ok};
         cnt_q <= cnt_q - 6'd1;
         if (cnt_q == 6'd1) begin
            run_q <= 1'b0;
         end
      end
   end

   // Flags the final iteration; quotient/remainder are settled the following cycle.
   assign done      = run_q && (cnt_q == 6'd1);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sched.sv
// Execute-stage scheduler for MULT/DIV/MTHI/MTLO that owns the HI/LO pair
// and stalls the pipeline while a multiply or divide is in flight.
module muldiv_sched
   import muldiv_pkg::*;
#(
   parameter int MUL_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  md_op_t      op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        stall_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t   state, next_state;
   logic [2:0]  mul_cnt;
   logic [63:0] mul_pipe [MUL_STAGES];
   logic [63:0] product;
   logic        is_muldiv_op, is_div_op, is_signed_op;
   logic        issue, div_start, mt_write, wb_commit;
   logic        pend_div, neg_q, neg_r, div_zero;
   logic [31:0] dividend_raw;
   logic [31:0] div_a, div_b, div_quo, div_rem;
   logic        div_done;
   logic [31:0] res_hi, res_lo;

   always_comb begin
      is_muldiv_op = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
      is_div_op    = (op == MD_DIV) || (op == MD_DIVU);
      is_signed_op = (op == MD_MULT) || (op == MD_DIV);
      issue        = (state == IDLE) && op_valid && is_muldiv_op && !flush;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: if (issue) next_state = is_div_op ? DIV : ((MUL_STAGES == 1) ? WB : MUL);
            MUL:  if (mul_cnt <= 3'd1) next_state = WB;
            DIV:  if (div_done) next_state = WB;
            WB:   next_state = stall_in ? HOLD : IDLE;
            HOLD: if (!stall_in) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = !flush && ((state == MUL) || (state == DIV) || issue);
      wb_commit = (state == WB) && !flush;
      done      = wb_commit;
      div_start = issue && is_div_op;
      mt_write  = (state == IDLE) && op_valid && !flush && !stall_in &&
                  ((op == MD_MTHI) || (op == MD_MTLO));
   end

   // 33-bit extension makes one unsigned 64-bit multiply serve both MULT and MULTU.
   always_comb begin
      logic [32:0] a33, b33;
      a33     = {is_signed_op & src_a[31], src_a};
      b33     = {is_signed_op & src_b[31], src_b};
      product = {{31{a33[32]}}, a33} * {{31{b33[32]}}, b33};
      div_a   = (is_signed_op && src_a[31]) ? (~src_a + 32'd1) : src_a;
      div_b   = (is_signed_op && src_b[31]) ? (~src_b + 32'd1) : src_b;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
      end else begin
         mul_pipe[0] <= product;
         for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end

   div_radix2 u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (flush),
      .dividend  (div_a),
      .divisor   (div_b),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   // Divide-by-zero bypasses the sign fix-up and returns the raw dividend in HI.
   always_comb begin
      if (!pend_div) begin
         {res_hi, res_lo} = mul_pipe[MUL_STAGES-1];
      end else if (div_zero) begin
         res_hi = dividend_raw;
         res_lo = 32'hFFFF_FFFF;
      end else begin
         res_hi = neg_r ? (~div_rem + 32'd1) : div_rem;
         res_lo = neg_q ? (~div_quo + 32'd1) : div_quo;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi           <= '0;
         lo           <= '0;
         mul_cnt      <= '0;
         pend_div     <= 1'b0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         div_zero     <= 1'b0;
         dividend_raw <= '0;
      end else begin
         if (issue) begin
            mul_cnt      <= 3'(MUL_STAGES - 1);
            pend_div     <= is_div_op;
            neg_q        <= is_signed_op && (src_a[31] ^ src_b[31]);
            neg_r        <= is_signed_op && src_a[31];
            div_zero     <= (src_b == 32'd0);
            dividend_raw <= src_a;
         end else if (state == MUL) begin
            mul_cnt <= mul_cnt - 3'd1;
         end
         if (wb_commit) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (mt_write) begin
            if (op == MD_MTHI) hi <= src_a;
            else               lo <= src_a;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: stimulus queues expected HI/LO commits,
// a negedge monitor pops them on every done pulse.
module tb_muldiv_sched;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   md_op_t      op;
   logic [31:0] src_a, src_b;
   logic        flush, stall_in;
   logic        busy, done;
   logic [31:0] hi, lo;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        cur;
   bit          cmp_pending = 1'b0;
   int          vectors = 0, miscompares = 0;
   int          sb_vectors = 0, sb_miscompares = 0;
   logic [31:0] exp_hi, exp_lo;

   always #5 clk = ~clk;

   muldiv_sched #(.MUL_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .flush    (flush),
      .stall_in (stall_in),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   // HI/LO become visible one negedge after the done pulse.
   always @(negedge clk) begin
      if (cmp_pending) begin
         sb_vectors++;
         if (hi !== cur.hi || lo !== cur.lo) begin
            sb_miscompares++;
            $display("[TB] FAIL %s: hi/lo = %h/%h, expected %h/%h", cur.name, hi, lo, cur.hi, cur.lo);
         end
         cmp_pending = 1'b0;
      end
      if (rst && done) begin
         sb_vectors++;
         if (sb_q.size() == 0) begin
            sb_miscompares++;
            $display("[TB] FAIL unexpected_done: done = 1, expected 0 (no commit pending)");
         end else begin
            cur = sb_q.pop_front();
            cmp_pending = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input logic v, input md_op_t o, input logic [31:0] a,
                                 input logic [31:0] b, input logic f, input logic s);
      op_valid = v;
      op       = o;
      src_a    = a;
      src_b    = b;
      flush    = f;
      stall_in = s;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_commit(input string name, input logic [31:0] h, input logic [31:0] l);
      exp_t e;
      e.name = name;
      e.hi   = h;
      e.lo   = l;
      sb_q.push_back(e);
      exp_hi = h;
      exp_lo = l;
   endtask

   task automatic run_div(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                          input string name, input logic [31:0] h, input logic [31:0] l);
      apply_stimulus(1'b1, o, a, b, 1'b0, 1'b0);
      push_commit(name, h, l);
      @(negedge clk);
      check_output({name, "_busy_issue"}, 32'(busy), 32'd1);
      cyc(32);
      @(negedge clk);
      check_output({name, "_busy_t32"}, 32'(busy), 32'd1);
      check_output({name, "_done_t32"}, 32'(done), 32'd0);
      cyc();
      @(negedge clk);
      check_output({name, "_done_wb"}, 32'(done), 32'd1);
      check_output({name, "_busy_wb"}, 32'(busy), 32'd0);
      cyc();
      apply_stimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      apply_stimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
      cyc(2);
      @(negedge clk);
      check_output("reset_hi", hi, 32'd0);
      check_output("reset_lo", lo, 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      cyc();
      rst = 1'b1;
      cyc();

      // MULT then back-to-back MULTU.
      apply_stimulus(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      push_commit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      @(negedge clk);
      check_output("mult_busy_issue", 32'(busy), 32'd1);
      cyc();
      @(negedge clk);
      check_output("mult_busy_t1", 32'(busy), 32'd1);
      check_output("mult_done_t1", 32'(done), 32'd0);
      cyc();
      @(negedge clk);
      check_output("mult_busy_wb", 32'(busy), 32'd0);
      check_output("mult_done_wb", 32'(done), 32'd1);
      cyc();
      apply_stimulus(1'b1, MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      push_commit("multu", 32'd2, 32'hFFFF_FFFA);
      @(negedge clk);
      check_output("multu_busy_issue", 32'(busy), 32'd1);
      cyc(2);
      @(negedge clk);
      check_output("multu_done_wb", 32'(done), 32'd1);
      cyc();
      apply_stimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
      cyc();

      run_div(MD_DIV,  32'hFFFF_FFF9, 32'd2,          "div_m7_2",   32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_div(MD_DIVU, 32'd7,         32'd0,          "divu_7_0",   32'd7,         32'hFFFF_FFFF);
      run_div(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  "div_ovf",    32'd0,         32'h8000_0000);
      run_div(MD_DIV,  32'hFFFF_FFFB, 32'd0,          "div_m5_0",   32'hFFFF_FFFB, 32'hFFFF_FFFF);

      // Flush ten cycles into a divide.
      apply_stimulus(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
      cyc(10);
      flush = 1'b1;
      @(negedge clk);
      check_output("flush_busy", 32'(busy), 32'd0);
      cyc();
      apply_stimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      check_output("flush_busy_after", 32'(busy), 32'd0);
      cyc(40);
      @(negedge clk);
      check_output("flush_hi_kept", hi, exp_hi);
      check_output("flush_lo_kept", lo, exp_lo);
      cyc();
      run_div(MD_DIVU, 32'd100, 32'd7, "divu_after_flush", 32'd2, 32'd14);

      // Downstream stall across the divide commit.
      apply_stimulus(1'b1, MD_DIV, 32'd20, 32'd3, 1'b0, 1'b0);
      push_commit("div_stall", 32'd2, 32'd6);
      cyc(30);
      stall_in = 1'b1;
      cyc();
      @(negedge clk);
      check_output("stall_busy_t31", 32'(busy), 32'd1);
      cyc(2);
      @(negedge clk);
      check_output("stall_done_t33", 32'(done), 32'd1);
      cyc(3);
      @(negedge clk);
      check_output("stall_busy_hold", 32'(busy), 32'd0);
      check_output("stall_done_hold", 32'(done), 32'd0);
      cyc(4);
      stall_in = 1'b0;
      @(negedge clk);
      check_output("stall_busy_t40", 32'(busy), 32'd0);
      cyc();
      apply_stimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      check_output("stall_busy_t41", 32'(busy), 32'd0);
      cyc(3);

      // MTHI held by stall, then MTLO.
      apply_stimulus(1'b1, MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      check_output("mthi_busy", 32'(busy), 32'd0);
      cyc();
      @(negedge clk);
      check_output("mthi_hi_stalled", hi, exp_hi);
      cyc();
      stall_in = 1'b0;
      @(negedge clk);
      check_output("mthi_hi_release", hi, exp_hi);
      cyc();
      exp_hi = 32'h1234_5678;
      apply_stimulus(1'b1, MD_MTLO, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      check_output("mthi_hi_written", hi, exp_hi);
      check_output("mtlo_lo_before", lo, exp_lo);
      cyc();
      exp_lo = 32'hA5A5_A5A5;
      apply_stimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      check_output("mtlo_lo_written", lo, exp_lo);
      check_output("mtlo_hi_kept", hi, exp_hi);
      cyc();

      // Asynchronous reset during a multiply.
      apply_stimulus(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0);
      cyc();
      #2;
      rst = 1'b0;
      apply_stimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
      #1;
      exp_hi = '0;
      exp_lo = '0;
      check_output("rst_mid_hi", hi, exp_hi);
      check_output("rst_mid_lo", lo, exp_lo);
      check_output("rst_mid_busy", 32'(busy), 32'd0);
      cyc(2);
      rst = 1'b1;
      cyc();
      apply_stimulus(1'b1, MD_MULT, 32'd5, 32'd6, 1'b0, 1'b0);
      push_commit("mult_5_6", 32'd0, 32'd30);
      cyc(2);
      @(negedge clk);
      check_output("mult56_done", 32'(done), 32'd1);
      cyc();
      apply_stimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
      cyc(3);

      check_output("sb_drained", 32'(sb_q.size()), 32'd0);
      vectors     += sb_vectors;
      miscompares += sb_miscompares;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
